tt_sweep_engine: RTL and testbench

//  Parametrised multi-channel truth-table engine. Holds NF programmable Boolean functions of NV inputs,

---
 rtl/tt_pkg.sv | 21 ++
 rtl/tt_channel.sv | 47 ++++
 rtl/tt_sweep_engine.sv | 117 +++++++++++
 tb/tb_tt_sweep_engine.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table sweep engine: FSM encoding, parameter limits
// and the per-channel ones-count field width.
package tt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int NV_MIN = 2;
    localparam int NV_MAX = 6;
    localparam int NF_MIN = 2;
    localparam int NF_MAX = 8;

    // One extra bit so an all-ones mask can report the full row count.
    function automatic int cnt_w(input int nv);
        return nv + 1;
    endfunction

endpackage

// File: rtl/tt_channel.sv
// One function channel: minterm mask register, row_out bit mux and ones counter.
// Mask writes are gated by the parent; counter clears on sweep start, increments on transfers.
module tt_channel
    import tt_pkg::*;
#(
    parameter int NV = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_we,
    input  logic [(1<<NV)-1:0]     i_mask,
    input  logic [NV-1:0]          i_row,
    input  logic                   i_clr,
    input  logic                   i_inc,
    output logic                   o_bit,
    output logic [cnt_w(NV)-1:0]   o_cnt
);

    localparam int CNTW = cnt_w(NV);

    logic [(1<<NV)-1:0] r_mask;
    logic [CNTW-1:0]    r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask <= '0;
        end else if (i_we) begin
            r_mask <= i_mask;
        end
    end

    // Pure register mux: stable for the whole cycle since both mask and row are registered.
    assign o_bit = r_mask[i_row];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && o_bit) begin
            r_cnt <= r_cnt + CNTW'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/tt_sweep_engine.sv
// Multi-channel truth-table engine: sweeps all 2^NV input rows over a valid/ready stream
// and counts minterms per channel. Holds row and counters while the consumer stalls.
module tt_sweep_engine
    import tt_pkg::*;
#(
    parameter int NV = 4,
    parameter int NF = 5
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cfg_we,
    input  logic [$clog2(NF)-1:0]       cfg_sel,
    input  logic [(1<<NV)-1:0]          cfg_mask,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        row_valid,
    input  logic                        row_ready,
    output logic [NV-1:0]               row_in,
    output logic [NF-1:0]               row_out,
    output logic [NF*cnt_w(NV)-1:0]     ones_cnt
);

    localparam int CW   = $clog2(NF);
    localparam int CNTW = cnt_w(NV);
    localparam logic [NV-1:0] LAST_ROW = '1;

    if (NV < NV_MIN || NV > NV_MAX || NF < NF_MIN || NF > NF_MAX) begin : g_bad_param
        $error("tt_sweep_engine: NV or NF outside the supported range");
    end

    state_t          r_state;
    logic            r_busy;
    logic            r_done;
    logic            r_valid;
    logic [NV-1:0]   r_row;

    logic            w_idle;
    logic            w_start_sweep;
    logic            w_xfer;

    assign w_idle        = (r_state == ST_IDLE);
    assign w_start_sweep = w_idle && start;
    assign w_xfer        = (r_state == ST_SWEEP) && r_valid && row_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_row   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= ST_SWEEP;
                        r_busy  <= 1'b1;
                        r_valid <= 1'b1;
                        r_row   <= '0;
                    end
                end
                ST_SWEEP: begin
                    // Last row leaves row_in parked at ROWS-1; it never wraps.
                    if (w_xfer) begin
                        if (r_row == LAST_ROW) begin
                            r_state <= ST_DONE;
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_row <= r_row + NV'(1);
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    genvar k;
    for (k = 0; k < NF; k++) begin : g_ch
        logic w_we;
        // Writes only land in IDLE, so masks are frozen for an entire sweep.
        assign w_we = w_idle && cfg_we && (cfg_sel == CW'(k));

        tt_channel #(
            .NV (NV)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .i_we   (w_we),
            .i_mask (cfg_mask),
            .i_row  (r_row),
            .i_clr  (w_start_sweep),
            .i_inc  (w_xfer),
            .o_bit  (row_out[k]),
            .o_cnt  (ones_cnt[k*CNTW +: CNTW])
        );
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign row_valid = r_valid;
    assign row_in    = r_row;

endmodule

// File: tb/tb_tt_sweep_engine.sv
// Directed bench for tt_sweep_engine: an NV=3/NF=2 instance for the small sweep,
// an NV=4/NF=5 instance for counting, backpressure, config gating, restart and reset.
module tb_tt_sweep_engine;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // NV=3, NF=2 instance
    logic        cfg_we_3 = 1'b0;
    logic        cfg_sel_3 = 1'b0;
    logic [7:0]  cfg_mask_3 = '0;
    logic        start_3 = 1'b0;
    logic        busy_3, done_3, row_valid_3;
    logic        row_ready_3 = 1'b0;
    logic [2:0]  row_in_3;
    logic [1:0]  row_out_3;
    logic [7:0]  ones_cnt_3;

    // NV=4, NF=5 instance
    logic        cfg_we_4 = 1'b0;
    logic [2:0]  cfg_sel_4 = '0;
    logic [15:0] cfg_mask_4 = '0;
    logic        start_4 = 1'b0;
    logic        busy_4, done_4, row_valid_4;
    logic        row_ready_4 = 1'b0;
    logic [3:0]  row_in_4;
    logic [4:0]  row_out_4;
    logic [24:0] ones_cnt_4;

    tt_sweep_engine #(.NV(3), .NF(2)) u_dut3 (
        .clk(clk), .reset(reset), .cfg_we(cfg_we_3), .cfg_sel(cfg_sel_3), .cfg_mask(cfg_mask_3),
        .start(start_3), .busy(busy_3), .done(done_3), .row_valid(row_valid_3), .row_ready(row_ready_3),
        .row_in(row_in_3), .row_out(row_out_3), .ones_cnt(ones_cnt_3)
    );

    tt_sweep_engine #(.NV(4), .NF(5)) u_dut4 (
        .clk(clk), .reset(reset), .cfg_we(cfg_we_4), .cfg_sel(cfg_sel_4), .cfg_mask(cfg_mask_4),
        .start(start_4), .busy(busy_4), .done(done_4), .row_valid(row_valid_4), .row_ready(row_ready_4),
        .row_in(row_in_4), .row_out(row_out_4), .ones_cnt(ones_cnt_4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [24:0] pack5(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                                          input logic [4:0] d, input logic [4:0] e);
        return {e, d, c, b, a};
    endfunction

    task automatic load4(input logic [2:0] sel, input logic [15:0] mask);
        cfg_we_4   = 1'b1;
        cfg_sel_4  = sel;
        cfg_mask_4 = mask;
        @(negedge clk);
        cfg_we_4 = 1'b0;
    endtask

    // Called at a negedge; any cfg write set by the caller shares the start cycle.
    task automatic run4(input string tg, input int stall_row, input int stall_len, input logic [24:0] stall_cnt,
                        input int poke_row, input bit poke_start, input bit poke_cfg,
                        input int exp_cycles, input logic [24:0] exp_cnt);
        int cycles;
        int stalled;
        cycles  = 0;
        stalled = 0;
        start_4     = 1'b1;
        row_ready_4 = 1'b1;
        @(negedge clk);
        cycles   = 1;
        start_4  = 1'b0;
        cfg_we_4 = 1'b0;
        while (!done_4 && cycles < 100) begin
            if (row_valid_4 && row_in_4 == stall_row && stalled < stall_len) begin
                row_ready_4 = 1'b0;
                if (stalled > 0) begin
                    check({tg, "_stall_row"}, row_in_4, stall_row);
                    check({tg, "_stall_cnt"}, ones_cnt_4, stall_cnt);
                end
                stalled++;
            end else begin
                row_ready_4 = 1'b1;
            end
            if (row_in_4 == poke_row) begin
                if (poke_start) start_4 = 1'b1;
                if (poke_cfg) begin
                    cfg_we_4   = 1'b1;
                    cfg_sel_4  = 3'd0;
                    cfg_mask_4 = 16'h0000;
                end
            end
            @(negedge clk);
            cycles++;
            start_4  = 1'b0;
            cfg_we_4 = 1'b0;
        end
        check({tg, "_done_seen"}, done_4, 1'b1);
        check({tg, "_latency"}, cycles, exp_cycles);
        check({tg, "_busy_in_done"}, busy_4, 1'b1);
        check({tg, "_valid_in_done"}, row_valid_4, 1'b0);
        check({tg, "_counts"}, ones_cnt_4, exp_cnt);
        @(negedge clk);
        check({tg, "_done_pulse"}, done_4, 1'b0);
        check({tg, "_busy_idle"}, busy_4, 1'b0);
        check({tg, "_counts_hold"}, ones_cnt_4, exp_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [7:0]  seq3;
        logic [24:0] e2;
        int          waited;

        // Reset state
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", busy_4, 1'b0);
        check("rst_done", done_4, 1'b0);
        check("rst_valid", row_valid_4, 1'b0);
        check("rst_row_in", row_in_4, 4'd0);
        check("rst_cnt", ones_cnt_4, 25'd0);
        check("rst_row_out", row_out_4, 5'd0);

        // 1: NV=3, ch0 = minterms 1,5,6,7
        cfg_we_3 = 1'b1; cfg_sel_3 = 1'b0; cfg_mask_3 = 8'b1110_0010;
        @(negedge clk);
        cfg_we_3 = 1'b0; start_3 = 1'b1; row_ready_3 = 1'b1;
        @(negedge clk);
        start_3 = 1'b0;
        seq3 = 8'b1110_0010;
        for (int r = 0; r < 8; r++) begin
            check("t1_valid", row_valid_3, 1'b1);
            check("t1_row_in", row_in_3, r);
            check("t1_row_out0", row_out_3[0], seq3[r]);
            check("t1_no_early_done", done_3, 1'b0);
            @(negedge clk);
        end
        check("t1_done_at_9", done_3, 1'b1);
        check("t1_cnt_ch0", ones_cnt_3[3:0], 4'd4);
        check("t1_cnt_ch1", ones_cnt_3[7:4], 4'd0);
        check("t1_row_in_parked", row_in_3, 3'd7);
        @(negedge clk);
        check("t1_done_pulse", done_3, 1'b0);
        check("t1_busy_idle", busy_3, 1'b0);

        // 2: NV=4 counting incl. all-ones and all-zeros, plus out-of-range select ignored
        load4(3'd0, 16'h8421);
        load4(3'd1, 16'hA5A5);
        load4(3'd2, 16'hFFFF);
        load4(3'd3, 16'h0000);
        load4(3'd4, 16'h0001);
        load4(3'd7, 16'h1234);
        e2 = pack5(5'd4, 5'd8, 5'd16, 5'd0, 5'd1);
        run4("t2", -1, 0, '0, -1, 1'b0, 1'b0, 17, e2);

        // 3: stall 3 cycles at row 2
        run4("t3", 2, 3, pack5(5'd1, 5'd1, 5'd2, 5'd0, 5'd1), -1, 1'b0, 1'b0, 20, e2);

        // 4a: write ch0 := 0 mid-sweep is ignored
        run4("t4a", -1, 0, '0, 3, 1'b0, 1'b1, 17, e2);

        // 5: start at row 5 mid-sweep is ignored
        run4("t5", -1, 0, '0, 5, 1'b1, 1'b0, 17, e2);

        // 4b: write + start in the same IDLE cycle uses the new mask
        cfg_we_4 = 1'b1; cfg_sel_4 = 3'd0; cfg_mask_4 = 16'h0007;
        run4("t4b", -1, 0, '0, -1, 1'b0, 1'b0, 17, pack5(5'd3, 5'd8, 5'd16, 5'd0, 5'd1));

        // 6: reset at row 7
        start_4 = 1'b1; row_ready_4 = 1'b1;
        @(negedge clk);
        start_4 = 1'b0;
        waited = 0;
        while (row_in_4 != 4'd7 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("t6_reached_row7", row_in_4, 4'd7);
        reset = 1'b1;
        @(negedge clk);
        check("t6_busy", busy_4, 1'b0);
        check("t6_valid", row_valid_4, 1'b0);
        check("t6_cnt", ones_cnt_4, 25'd0);
        check("t6_row_in", row_in_4, 4'd0);
        check("t6_row_out", row_out_4, 5'd0);
        reset = 1'b0;
        @(negedge clk);
        run4("t6_after", -1, 0, '0, -1, 1'b0, 1'b0, 17, 25'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
